cpu_control_unit: RTL and testbench

//  Multi-cycle control FSM for the 16-bit RISC CPU; sits directly upstream of the execution unit.

---
 rtl/cpu_control_unit_pkg.sv | 34 +++
 rtl/cpu_control_unit_if.sv | 24 ++
 rtl/cpu_branch_cond.sv | 29 ++
 rtl/cpu_control_unit.sv | 179 +++++++++++++++++
 tb/tb_cpu_control_unit.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_control_unit_pkg.sv
// Shared encodings for the 16-bit RISC control unit: instruction classes, branch
// condition codes, FSM states and default ALU pass-through opcodes.
package cpu_control_unit_pkg;

  typedef enum logic [2:0] {
    ClsAlu    = 3'b000,
    ClsLoad   = 3'b001,
    ClsStore  = 3'b010,
    ClsBranch = 3'b011,
    ClsJr     = 3'b100,
    ClsBad5   = 3'b101,
    ClsBad6   = 3'b110,
    ClsHalt   = 3'b111
  } cls_e;

  typedef enum logic [2:0] {
    CcAlways = 3'b000,
    CcZ      = 3'b001,
    CcNz     = 3'b010,
    CcN      = 3'b011,
    CcNn     = 3'b100,
    CcC      = 3'b101,
    CcNc     = 3'b110,
    CcBad    = 3'b111
  } cc_e;

  typedef enum logic [3:0] {
    StRst, StFetch, StDecode, StExecAlu, StMemRd, StMemWr, StBranch, StJr, StHalt
  } state_e;

  localparam logic [3:0] AluPassSDefault = 4'h1;
  localparam logic [3:0] AluPassRDefault = 4'h0;

endpackage

// File: rtl/cpu_control_unit_if.sv
// Control-unit <-> execution-unit/memory signal bundle. The control unit is the
// master; the EU and memory (or a bench) sit on the slave side.
interface cpu_control_unit_if;
  logic [15:0] IR_in;
  logic        N, Z, C;
  logic        mem_ack;
  logic        W_en, S_Sel, Adr_Sel, PC_ld, IR_ld, PC_inc, PC_sel;
  logic [3:0]  ALU_OP;
  logic [2:0]  W_adr, S_adr, R_adr;
  logic        mem_rd, mem_wr;
  logic        halted, illegal, bus_err;

  modport master (
    input  IR_in, N, Z, C, mem_ack,
    output W_en, S_Sel, Adr_Sel, PC_ld, IR_ld, PC_inc, PC_sel, ALU_OP,
           W_adr, S_adr, R_adr, mem_rd, mem_wr, halted, illegal, bus_err
  );

  modport slave (
    output IR_in, N, Z, C, mem_ack,
    input  W_en, S_Sel, Adr_Sel, PC_ld, IR_ld, PC_inc, PC_sel, ALU_OP,
           W_adr, S_adr, R_adr, mem_rd, mem_wr, halted, illegal, bus_err
  );
endinterface

// File: rtl/cpu_branch_cond.sv
// Branch condition evaluation on latched ALU flags; cc 111 is reserved and
// reported as bad_cc instead of being taken.
module cpu_branch_cond
  import cpu_control_unit_pkg::*;
(
  input  cc_e  cc,
  input  logic fN,
  input  logic fZ,
  input  logic fC,
  output logic take,
  output logic bad_cc
);

  always_comb begin
    take   = 1'b0;
    bad_cc = 1'b0;
    unique case (cc)
      CcAlways: take = 1'b1;
      CcZ:      take = fZ;
      CcNz:     take = ~fZ;
      CcN:      take = fN;
      CcNn:     take = ~fN;
      CcC:      take = fC;
      CcNc:     take = ~fC;
      CcBad:    bad_cc = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM for the 16-bit RISC CPU: fetch/decode/execute sequencing,
// memory handshake with wait timeout, branch evaluation and sticky fault flags.
module cpu_control_unit
  import cpu_control_unit_pkg::*;
#(
  parameter logic [3:0]  ALU_PASS_S  = AluPassSDefault,
  parameter logic [3:0]  ALU_PASS_R  = AluPassRDefault,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic          clk,
  input logic          reset,
  cpu_control_unit_if.master bus
);

  // Counter only needs to reach MEM_TIMEOUT-1; the limit cycle itself triggers the halt.
  localparam int unsigned    CntW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fn_q, fz_q, fc_q, cap_flags;
  logic            halted_q, illegal_q, bus_err_q;
  logic            set_illegal, set_bus_err;
  logic            req, take, bad_cc;

  cls_e       cls;
  cc_e        cc;
  logic [3:0] op;
  logic [2:0] w, r, s;

  assign cls = cls_e'(bus.IR_in[15:13]);
  assign op  = bus.IR_in[12:9];
  assign w   = bus.IR_in[8:6];
  assign r   = bus.IR_in[5:3];
  assign s   = bus.IR_in[2:0];
  assign cc  = cc_e'(bus.IR_in[10:8]);

  cpu_branch_cond u_branch_cond (
    .cc     (cc),
    .fN     (fn_q),
    .fZ     (fz_q),
    .fC     (fc_q),
    .take   (take),
    .bad_cc (bad_cc)
  );

  assign bus.halted  = halted_q;
  assign bus.illegal = illegal_q;
  assign bus.bus_err = bus_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    req         = 1'b0;
    cap_flags   = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    bus.W_en    = 1'b0;
    bus.S_Sel   = 1'b0;
    bus.Adr_Sel = 1'b0;
    bus.PC_ld   = 1'b0;
    bus.IR_ld   = 1'b0;
    bus.PC_inc  = 1'b0;
    bus.PC_sel  = 1'b0;
    bus.ALU_OP  = 4'h0;
    bus.W_adr   = 3'd0;
    bus.S_adr   = 3'd0;
    bus.R_adr   = 3'd0;
    bus.mem_rd  = 1'b0;
    bus.mem_wr  = 1'b0;

    case (state_q)
      StRst: state_d = StFetch;
      StFetch: begin
        req        = 1'b1;
        bus.mem_rd = 1'b1;
        if (bus.mem_ack) begin
          bus.IR_ld  = 1'b1;
          bus.PC_inc = 1'b1;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        case (cls)
          ClsAlu:    state_d = StExecAlu;
          ClsLoad:   state_d = StMemRd;
          ClsStore:  state_d = StMemWr;
          ClsBranch: begin
            state_d     = bad_cc ? StHalt : StBranch;
            set_illegal = bad_cc;
          end
          ClsJr:     state_d = StJr;
          ClsHalt:   state_d = StHalt;
          default: begin
            state_d     = StHalt;
            set_illegal = 1'b1;
          end
        endcase
      end
      StExecAlu: begin
        bus.ALU_OP = op;
        bus.W_adr  = w;
        bus.R_adr  = r;
        bus.S_adr  = s;
        bus.W_en   = 1'b1;
        cap_flags  = 1'b1;
        state_d    = StFetch;
      end
      StMemRd: begin
        req         = 1'b1;
        bus.Adr_Sel = 1'b1;
        bus.R_adr   = r;
        bus.mem_rd  = 1'b1;
        bus.S_Sel   = 1'b1;
        bus.ALU_OP  = ALU_PASS_S;
        bus.W_adr   = w;
        bus.W_en    = bus.mem_ack;
        if (bus.mem_ack) state_d = StFetch;
      end
      StMemWr: begin
        req         = 1'b1;
        bus.Adr_Sel = 1'b1;
        bus.R_adr   = r;
        bus.S_adr   = s;
        bus.ALU_OP  = ALU_PASS_S;
        bus.mem_wr  = 1'b1;
        if (bus.mem_ack) state_d = StFetch;
      end
      StBranch: begin
        bus.PC_ld = take;
        state_d   = StFetch;
      end
      StJr: begin
        bus.R_adr  = r;
        bus.ALU_OP = ALU_PASS_R;
        bus.PC_sel = 1'b1;
        bus.PC_ld  = 1'b1;
        state_d    = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StRst;
    endcase

    // An ack in the limit cycle wins, since only ack-less request cycles count.
    if (req && !bus.mem_ack) begin
      if (MEM_TIMEOUT != 0 && cnt_q == CntLast) begin
        state_d     = StHalt;
        set_bus_err = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StRst;
      cnt_q     <= '0;
      fn_q      <= 1'b0;
      fz_q      <= 1'b0;
      fc_q      <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap_flags) begin
        fn_q <= bus.N;
        fz_q <= bus.Z;
        fc_q <= bus.C;
      end
      if (state_d == StHalt) halted_q  <= 1'b1;
      if (set_illegal)       illegal_q <= 1'b1;
      if (set_bus_err)       bus_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench: directed and random instruction streams compared cycle by cycle
// against an instruction-level model of the control unit's strobe sequence.
module tb_cpu_control_unit;

  typedef struct packed {
    logic       w_en, s_sel, adr_sel, pc_ld, ir_ld, pc_inc, pc_sel;
    logic [3:0] alu_op;
    logic [2:0] w_adr, s_adr, r_adr;
    logic       mem_rd, mem_wr, halted, illegal, bus_err;
  } out_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cpu_control_unit_if bus ();
  cpu_control_unit_if bus_t ();

  cpu_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  cpu_control_unit #(.MEM_TIMEOUT(4)) dut_t (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_t.master)
  );

  out_t obs_m, obs_t;
  assign obs_m = {bus.W_en, bus.S_Sel, bus.Adr_Sel, bus.PC_ld, bus.IR_ld, bus.PC_inc,
                  bus.PC_sel, bus.ALU_OP, bus.W_adr, bus.S_adr, bus.R_adr, bus.mem_rd,
                  bus.mem_wr, bus.halted, bus.illegal, bus.bus_err};
  assign obs_t = {bus_t.W_en, bus_t.S_Sel, bus_t.Adr_Sel, bus_t.PC_ld, bus_t.IR_ld,
                  bus_t.PC_inc, bus_t.PC_sel, bus_t.ALU_OP, bus_t.W_adr, bus_t.S_adr,
                  bus_t.R_adr, bus_t.mem_rd, bus_t.mem_wr, bus_t.halted, bus_t.illegal,
                  bus_t.bus_err};

  int   n_checks = 0;
  int   n_pass = 0;
  logic m_halt, m_ill, m_berr, m_fn, m_fz, m_fc;
  logic cur_n, cur_z, cur_c;
  logic z_fix_en, z_fix;

  task automatic check(input string tag, input out_t o, input out_t e);
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask

  function automatic out_t base();
    out_t e = '0;
    e.halted  = m_halt;
    e.illegal = m_ill;
    e.bus_err = m_berr;
    return e;
  endfunction

  function automatic out_t e_fetch(input logic ack);
    out_t e = base();
    e.mem_rd = 1'b1;
    e.ir_ld  = ack;
    e.pc_inc = ack;
    return e;
  endfunction

  function automatic out_t e_alu(input logic [15:0] ir);
    out_t e = base();
    e.alu_op = ir[12:9];
    e.w_adr  = ir[8:6];
    e.r_adr  = ir[5:3];
    e.s_adr  = ir[2:0];
    e.w_en   = 1'b1;
    return e;
  endfunction

  function automatic out_t e_ld(input logic [15:0] ir, input logic ack);
    out_t e = base();
    e.adr_sel = 1'b1;
    e.r_adr   = ir[5:3];
    e.mem_rd  = 1'b1;
    e.s_sel   = 1'b1;
    e.alu_op  = 4'h1;
    e.w_adr   = ir[8:6];
    e.w_en    = ack;
    return e;
  endfunction

  function automatic out_t e_st(input logic [15:0] ir);
    out_t e = base();
    e.adr_sel = 1'b1;
    e.r_adr   = ir[5:3];
    e.s_adr   = ir[2:0];
    e.alu_op  = 4'h1;
    e.mem_wr  = 1'b1;
    return e;
  endfunction

  function automatic out_t e_jr(input logic [15:0] ir);
    out_t e = base();
    e.r_adr  = ir[5:3];
    e.alu_op = 4'h0;
    e.pc_sel = 1'b1;
    e.pc_ld  = 1'b1;
    return e;
  endfunction

  // One clock: drive inputs after the falling edge, then compare the main DUT.
  task automatic step(input out_t e, input logic ack, input string tag);
    @(negedge clk);
    bus.mem_ack = ack;
    cur_n = 1'($urandom);
    cur_z = z_fix_en ? z_fix : 1'($urandom);
    cur_c = 1'($urandom);
    bus.N = cur_n;
    bus.Z = cur_z;
    bus.C = cur_c;
    #1;
    check(tag, obs_m, e);
  endtask

  task automatic halt_cycles(input string tag);
    for (int i = 0; i < 2; i++) step(base(), 1'($urandom), tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    bus.mem_ack = 1'b0;
    {m_halt, m_ill, m_berr, m_fn, m_fz, m_fc} = '0;
    #1;
    check({tag, "_assert"}, obs_m, '0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check({tag, "_release"}, obs_m, '0);
  endtask

  task automatic run_instr(input logic [15:0] ir, input int fw, input int mw);
    logic [2:0] cls, cc;
    logic       take;
    cls = ir[15:13];
    cc  = ir[10:8];
    bus.IR_in = ir;
    for (int i = 0; i < fw; i++) step(e_fetch(1'b0), 1'b0, "fetch_wait");
    step(e_fetch(1'b1), 1'b1, "fetch_ack");
    step(base(), 1'($urandom), "decode");
    case (cls)
      3'b000: begin
        step(e_alu(ir), 1'($urandom), "alu");
        m_fn = cur_n;
        m_fz = cur_z;
        m_fc = cur_c;
      end
      3'b001: begin
        for (int i = 0; i < mw; i++) step(e_ld(ir, 1'b0), 1'b0, "load_wait");
        step(e_ld(ir, 1'b1), 1'b1, "load_ack");
      end
      3'b010: begin
        for (int i = 0; i < mw; i++) step(e_st(ir), 1'b0, "store_wait");
        step(e_st(ir), 1'b1, "store_ack");
      end
      3'b011: begin
        if (cc == 3'd7) begin
          m_halt = 1'b1;
          m_ill  = 1'b1;
          halt_cycles("bad_cc");
        end else begin
          case (cc)
            3'd0:    take = 1'b1;
            3'd1:    take = m_fz;
            3'd2:    take = ~m_fz;
            3'd3:    take = m_fn;
            3'd4:    take = ~m_fn;
            3'd5:    take = m_fc;
            default: take = ~m_fc;
          endcase
          begin
            out_t e = base();
            e.pc_ld = take;
            step(e, 1'($urandom), "branch");
          end
        end
      end
      3'b100: step(e_jr(ir), 1'($urandom), "jr");
      3'b111: begin
        m_halt = 1'b1;
        halt_cycles("halt_instr");
      end
      default: begin
        m_halt = 1'b1;
        m_ill  = 1'b1;
        halt_cycles("illegal_cls");
      end
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ir;
    out_t        et;
    int unsigned pick;

    bus.IR_in = 16'h0;
    {bus.N, bus.Z, bus.C, bus.mem_ack} = '0;
    bus_t.IR_in = 16'h0;
    {bus_t.N, bus_t.Z, bus_t.C, bus_t.mem_ack} = '0;
    z_fix_en = 1'b0;
    z_fix = 1'b0;
    {cur_n, cur_z, cur_c} = '0;

    do_reset("init");

    // Both DUTs wait in FETCH; the MEM_TIMEOUT=4 copy gives up after 4 wait cycles.
    bus.IR_in = 16'h0A53;
    for (int k = 0; k < 6; k++) begin
      step(e_fetch(1'b0), 1'b0, "fetch_wait");
      et = '0;
      if (k < 4) et.mem_rd = 1'b1;
      else begin
        et.halted  = 1'b1;
        et.bus_err = 1'b1;
      end
      check("timeout4", obs_t, et);
    end
    run_instr(16'h0A53, 0, 0);

    z_fix_en = 1'b1;
    z_fix = 1'b1;
    run_instr(16'h0A53, 0, 0);
    z_fix_en = 1'b0;
    run_instr(16'h61FC, 0, 0);
    z_fix_en = 1'b1;
    z_fix = 1'b0;
    run_instr(16'h0A53, 0, 0);
    z_fix_en = 1'b0;
    run_instr(16'h61FC, 0, 0);

    run_instr(16'h2128, 0, 2);
    run_instr(16'h8018, 0, 0);
    run_instr(16'h4A5E, 1, 1);
    run_instr(16'h0A53, 15, 0);
    run_instr(16'h2128, 0, 15);

    bus.IR_in = 16'h2128;
    step(e_fetch(1'b1), 1'b1, "fetch_ack");
    step(base(), 1'b0, "decode");
    step(e_ld(16'h2128, 1'b0), 1'b0, "load_wait");
    do_reset("midop");

    run_instr(16'hA000, 0, 0);
    do_reset("illegal");
    run_instr(16'hE000, 0, 0);
    do_reset("halt");
    run_instr(16'h6700, 0, 0);
    do_reset("badcc");

    bus.IR_in = 16'h0A53;
    for (int k = 0; k < 16; k++) step(e_fetch(1'b0), 1'b0, "fetch_to");
    m_halt = 1'b1;
    m_berr = 1'b1;
    halt_cycles("timeout16");
    do_reset("to16");

    for (int n = 0; n < 150; n++) begin
      pick = $urandom_range(0, 19);
      ir = 16'($urandom);
      if (pick < 6)       ir[15:13] = 3'b000;
      else if (pick < 9)  ir[15:13] = 3'b001;
      else if (pick < 12) ir[15:13] = 3'b010;
      else if (pick < 16) begin
        ir[15:13] = 3'b011;
        ir[10:8]  = 3'($urandom_range(0, 6));
      end
      else if (pick < 18) ir[15:13] = 3'b100;
      else if (pick < 19) ir[15:13] = 3'b111;
      else                ir[15:13] = 3'($urandom_range(5, 6));
      run_instr(ir, $urandom_range(0, 3), $urandom_range(0, 3));
      if (m_halt) do_reset("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
